systolic_array_ctrl: RTL and testbench
======================================

// Module: systolic_array_ctrl
// PURPOSE
//  Sequencer for the ARRAY_N x ARRAY_M systolic_array tile. It accepts a tile descriptor and runs
//  cfg_num_k reduction passes over cfg_num_rows activation rows. For each pass it issues the
//  ibuf/wbuf/bbuf/obuf read requests and the delayed obuf write requests, bias_prev_sw and
//  acc_clear. It sits between the layer scheduler (start/done) and systolic_array + buffers.
// PARAMETERS
//  ARRAY_N          4   PE rows (input lanes)
//  ARRAY_M          4   PE cols (output lanes)
//  IBUF_ADDR_WIDTH  16  activation buffer address width
//  WBUF_ADDR_WIDTH  16  weight buffer address width
//  BBUF_ADDR_WIDTH  16  bias buffer address width
//  OBUF_ADDR_WIDTH  16  output buffer address width
//  LOOP_WIDTH       16  width of row / pass counters
//  SA_LATENCY       9   cycles from ibuf_read_req to matching obuf_write_req (>=2)
// PORTS
//  clk              in   1   clock, rising edge
//  reset            in   1   synchronous, active-low reset (0 = reset)
//  start            in   1   one-cycle tile start; sampled only in IDLE
//  cfg_num_rows     in   LOOP_WIDTH  rows per pass
//  cfg_num_k        in   LOOP_WIDTH  reduction passes
//  cfg_ibuf_base    in   IBUF_ADDR_WIDTH   first activation address
//  cfg_wbuf_base    in   WBUF_ADDR_WIDTH   first weight-tile address
//  cfg_bbuf_base    in   BBUF_ADDR_WIDTH   bias address
//  cfg_obuf_base    in   OBUF_ADDR_WIDTH   first output row address
//  busy / done      out  1 / 1   tile active / one-cycle completion pulse
//  acc_clear        out  1   clear array accumulators
//  ibuf_read_req / ibuf_read_addr   out  1 / IBUF_ADDR_WIDTH
//  wbuf_read_req / wbuf_read_addr   out  1 / WBUF_ADDR_WIDTH
//  bias_read_req / bias_read_addr   out  1 / BBUF_ADDR_WIDTH
//  bias_prev_sw     out  1   0: add bias, 1: add previous obuf partial sum
//  obuf_read_req / obuf_read_addr   out  1 / OBUF_ADDR_WIDTH
//  obuf_write_req / obuf_write_addr out  1 / OBUF_ADDR_WIDTH
//  perf_cycle_count out  32  busy-cycle counter (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset=0 at edge): state IDLE; every output 0, including addresses; delay line flushed;
//    no write is issued for an aborted tile.
//  - FSM: IDLE -> LOAD -> WGT -> ROWS -> (WGT | PASS_WAIT | DRAIN) ; PASS_WAIT -> WGT ; DRAIN -> IDLE.
//  - IDLE: on start=1, cfg_* are latched. start is ignored while busy. busy=1 in every state except IDLE.
//  - LOAD (1 cycle): acc_clear=1, k=0. If cfg_num_rows==0 or cfg_num_k==0, go to DRAIN: no requests,
//    and done is asserted in the cycle after LOAD.
//  - WGT (1 cycle): wbuf_read_req=1, wbuf_read_addr=wbuf_base+k; r=0.
//  - ROWS (cfg_num_rows cycles): ibuf_read_req=1, ibuf_read_addr=ibuf_base+k*num_rows+r.
//    In the same cycle: if k==0, bias_read_req=1 with bias_read_addr=bbuf_base; else obuf_read_req=1
//    with obuf_read_addr=obuf_base+r. bias_prev_sw=(k!=0), held from WGT to end of pass.
//    Row (obuf_base+r) is pushed into the delay line.
//  - Write: obuf_write_req=1 and obuf_write_addr=obuf_base+r exactly SA_LATENCY cycles after the
//    issuing ROWS cycle. The delay line is a valid+addr shift register with depth SA_LATENCY.
//  - End of pass: if k+1<num_k, go to WGT. If num_rows<SA_LATENCY, go to PASS_WAIT instead until the
//    delay line is empty (RAW hazard on obuf), then go to WGT. After the last pass, go to DRAIN.
//  - DRAIN: wait until the delay line is empty. done=1 for exactly one cycle, in the cycle after the
//    last obuf_write_req. Next state IDLE; busy=0 from the following cycle.
//  - Address arithmetic: modulo 2^ADDR_WIDTH. k*num_rows is truncated to IBUF_ADDR_WIDTH, and
//    wrap-around is legal. Counters are LOOP_WIDTH unsigned.
// CONFIGURATION
//  SA_CTRL_PERF_EN defined: perf_cycle_count clears on start acceptance. It increments in every
//    cycle with busy=1, saturates at 2^32-1, and holds after done until the next start.
//  SA_CTRL_PERF_EN undefined: the port is still present and tied to 32'd0; no counter logic.
// STRUCTURE
//  - Shared package systolic_ctrl_pkg holds:
//    state encoding localparams (IDLE, LOAD, WGT, ROWS, PASS_WAIT, DRAIN);
//    the default SA_LATENCY value;
//    the descriptor field widths.
//  - One sub-module, sa_ctrl_delay_line: parameterised depth/width shift register with an
//    any_valid flag. The FSM and counters stay in the top module.
// TESTING  (cycle 0 = cycle start=1 is sampled)
//  1. rows=16, k=2, SA_LATENCY=9:
//     - WGT in cycles 2 and 19; ROWS 3-18 and 20-35; ibuf addrs base+0..31.
//     - bias_read_req in 3-18, obuf_read_req in 20-35.
//     - writes in 12-27 and 29-44; done in cycle 45; perf_cycle_count=45.
//  2. rows=4, k=2 (hazard):
//     - pass-0 writes 12-15; PASS_WAIT until then; WGT in cycle 16.
//     - ROWS 17-20; writes 26-29; done in cycle 30.
//     - No obuf_read_req precedes the write to the same address.
//  3. rows=0 or k=0: no read or write request at all; done in cycle 2; busy cycles 1-2.
//  4. reset=0 in cycle 10 of scenario 1: from cycle 11 all outputs are 0, no further writes,
//     no done; a new start runs cleanly.
//  5. start pulsed again in cycle 5 of scenario 1: it is ignored, and the outputs are identical
//     to scenario 1.
//  6. obuf_base=16'hFFFE, rows=4: write addrs FFFE, FFFF, 0000, 0001.
//     Build without SA_CTRL_PERF_EN: perf_cycle_count is always 0.

Source files
------------

// File: rtl/systolic_ctrl_pkg.sv
// Shared definitions for the systolic array sequencer: state encoding, default latency and
// descriptor field widths.
package systolic_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StLoad     = 3'd1,
    StWgt      = 3'd2,
    StRows     = 3'd3,
    StPassWait = 3'd4,
    StDrain    = 3'd5
  } ctrl_state_e;

  localparam int unsigned SaLatencyDefault = 9;
  localparam int unsigned LoopWidthDefault = 16;
  localparam int unsigned AddrWidthDefault = 16;
  localparam int unsigned PerfWidth        = 32;

endpackage

// File: rtl/sa_ctrl_delay_line.sv
// Valid+data shift register that delays each issued row address until its result leaves the
// array; reports whether anything is in flight.
module sa_ctrl_delay_line
  import systolic_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = SaLatencyDefault,
  parameter int unsigned WIDTH = AddrWidthDefault
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             any_valid,
  output logic             pending
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q   <= {valid_q[DEPTH-2:0], in_valid};
      data_q[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign any_valid = |valid_q;
  // Entries still in flight other than the one leaving this cycle.
  assign pending   = |valid_q[DEPTH-2:0];

endmodule

// File: rtl/systolic_array_ctrl.sv
// Tile sequencer for the systolic array: issues buffer reads per pass and delayed obuf writes.
// Optional busy-cycle counter enabled by defining SA_CTRL_PERF_EN.
module systolic_array_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int unsigned ARRAY_N         = 4,
  parameter int unsigned ARRAY_M         = 4,
  parameter int unsigned IBUF_ADDR_WIDTH = AddrWidthDefault,
  parameter int unsigned WBUF_ADDR_WIDTH = AddrWidthDefault,
  parameter int unsigned BBUF_ADDR_WIDTH = AddrWidthDefault,
  parameter int unsigned OBUF_ADDR_WIDTH = AddrWidthDefault,
  parameter int unsigned LOOP_WIDTH      = LoopWidthDefault,
  parameter int unsigned SA_LATENCY      = SaLatencyDefault
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [LOOP_WIDTH-1:0]      cfg_num_rows,
  input  logic [LOOP_WIDTH-1:0]      cfg_num_k,
  input  logic [IBUF_ADDR_WIDTH-1:0] cfg_ibuf_base,
  input  logic [WBUF_ADDR_WIDTH-1:0] cfg_wbuf_base,
  input  logic [BBUF_ADDR_WIDTH-1:0] cfg_bbuf_base,
  input  logic [OBUF_ADDR_WIDTH-1:0] cfg_obuf_base,
  output logic                       busy,
  output logic                       done,
  output logic                       acc_clear,
  output logic                       ibuf_read_req,
  output logic [IBUF_ADDR_WIDTH-1:0] ibuf_read_addr,
  output logic                       wbuf_read_req,
  output logic [WBUF_ADDR_WIDTH-1:0] wbuf_read_addr,
  output logic                       bias_read_req,
  output logic [BBUF_ADDR_WIDTH-1:0] bias_read_addr,
  output logic                       bias_prev_sw,
  output logic                       obuf_read_req,
  output logic [OBUF_ADDR_WIDTH-1:0] obuf_read_addr,
  output logic                       obuf_write_req,
  output logic [OBUF_ADDR_WIDTH-1:0] obuf_write_addr,
  output logic [PerfWidth-1:0]       perf_cycle_count
);

  if (ARRAY_N == 0 || ARRAY_M == 0 || SA_LATENCY < 2) begin : g_bad_cfg
    $error("systolic_array_ctrl: invalid parameter set");
  end

  ctrl_state_e state_q, state_d;

  logic [LOOP_WIDTH-1:0]      num_rows_q, num_k_q;
  logic [LOOP_WIDTH-1:0]      k_q, r_q;
  logic [IBUF_ADDR_WIDTH-1:0] ibuf_ptr_q;
  logic [WBUF_ADDR_WIDTH-1:0] wbuf_base_q;
  logic [BBUF_ADDR_WIDTH-1:0] bbuf_base_q;
  logic [OBUF_ADDR_WIDTH-1:0] obuf_base_q;

  logic                       last_row, more_k, rows_short, tile_empty;
  logic [OBUF_ADDR_WIDTH-1:0] row_obuf_addr;
  logic                       dl_out_valid, dl_any_valid, dl_pending;
  logic [OBUF_ADDR_WIDTH-1:0] dl_out_data;

  assign last_row      = (r_q == num_rows_q - LOOP_WIDTH'(1));
  assign more_k        = ((k_q + LOOP_WIDTH'(1)) < num_k_q);
  assign rows_short    = (32'(num_rows_q) < SA_LATENCY);
  assign tile_empty    = (num_rows_q == '0) || (num_k_q == '0);
  assign row_obuf_addr = obuf_base_q + OBUF_ADDR_WIDTH'(r_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (start) state_d = StLoad;
      StLoad:     state_d = tile_empty ? StDrain : StWgt;
      StWgt:      state_d = StRows;
      StRows: begin
        if (last_row) begin
          if (!more_k)         state_d = StDrain;
          else if (rows_short) state_d = StPassWait;
          else                 state_d = StWgt;
        end
      end
      // Next pass reads partial sums back, so the previous writes must have landed first.
      StPassWait: if (!dl_pending) state_d = StWgt;
      StDrain:    if (!dl_any_valid) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      num_rows_q  <= '0;
      num_k_q     <= '0;
      k_q         <= '0;
      r_q         <= '0;
      ibuf_ptr_q  <= '0;
      wbuf_base_q <= '0;
      bbuf_base_q <= '0;
      obuf_base_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            num_rows_q  <= cfg_num_rows;
            num_k_q     <= cfg_num_k;
            ibuf_ptr_q  <= cfg_ibuf_base;
            wbuf_base_q <= cfg_wbuf_base;
            bbuf_base_q <= cfg_bbuf_base;
            obuf_base_q <= cfg_obuf_base;
          end
        end
        StLoad: k_q <= '0;
        StWgt:  r_q <= '0;
        StRows: begin
          // Running pointer equals ibuf_base + k*num_rows + r, modulo the address width.
          r_q        <= r_q + LOOP_WIDTH'(1);
          ibuf_ptr_q <= ibuf_ptr_q + IBUF_ADDR_WIDTH'(1);
          if (last_row && more_k) k_q <= k_q + LOOP_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  sa_ctrl_delay_line #(
    .DEPTH(SA_LATENCY),
    .WIDTH(OBUF_ADDR_WIDTH)
  ) u_delay_line (
    .clk      (clk),
    .reset    (reset),
    .in_valid (state_q == StRows),
    .in_data  (row_obuf_addr),
    .out_valid(dl_out_valid),
    .out_data (dl_out_data),
    .any_valid(dl_any_valid),
    .pending  (dl_pending)
  );

  always_comb begin
    busy            = (state_q != StIdle);
    done            = (state_q == StDrain) && !dl_any_valid;
    acc_clear       = (state_q == StLoad);
    wbuf_read_req   = (state_q == StWgt);
    wbuf_read_addr  = '0;
    ibuf_read_req   = (state_q == StRows);
    ibuf_read_addr  = '0;
    bias_read_req   = (state_q == StRows) && (k_q == '0);
    bias_read_addr  = '0;
    obuf_read_req   = (state_q == StRows) && (k_q != '0);
    obuf_read_addr  = '0;
    bias_prev_sw    = ((state_q == StWgt) || (state_q == StRows)) && (k_q != '0);
    obuf_write_req  = dl_out_valid;
    obuf_write_addr = dl_out_valid ? dl_out_data : '0;
    if (wbuf_read_req) wbuf_read_addr = wbuf_base_q + WBUF_ADDR_WIDTH'(k_q);
    if (ibuf_read_req) ibuf_read_addr = ibuf_ptr_q;
    if (bias_read_req) bias_read_addr = bbuf_base_q;
    if (obuf_read_req) obuf_read_addr = row_obuf_addr;
  end

`ifdef SA_CTRL_PERF_EN
  logic [PerfWidth-1:0] perf_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_q <= '0;
    end else if (state_q == StIdle) begin
      if (start) perf_q <= '0;
    end else if (perf_q != '1) begin
      perf_q <= perf_q + PerfWidth'(1);
    end
  end

  assign perf_cycle_count = perf_q;
`else
  assign perf_cycle_count = '0;
`endif

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl: records each tile cycle by cycle and compares against
// hand-derived windows.
module tb_systolic_array_ctrl;

  localparam int NC = 64;
`ifdef SA_CTRL_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] cfg_num_rows, cfg_num_k, cfg_ibuf_base, cfg_wbuf_base, cfg_bbuf_base, cfg_obuf_base;
  logic        busy, done, acc_clear, ibuf_read_req, wbuf_read_req, bias_read_req, bias_prev_sw;
  logic        obuf_read_req, obuf_write_req;
  logic [15:0] ibuf_read_addr, wbuf_read_addr, bias_read_addr, obuf_read_addr, obuf_write_addr;
  logic [31:0] perf_cycle_count;

  int n_cmp = 0;
  int n_err = 0;

  // {busy,done,acc_clear,wreq,ireq,breq,bsw,oreq,wrreq, waddr,iaddr,baddr,oaddr,wraddr}
  logic [88:0] rec_vec  [NC];
  logic [31:0] rec_perf [NC];

  always #5 clk = ~clk;

  systolic_array_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .cfg_num_rows    (cfg_num_rows),
    .cfg_num_k       (cfg_num_k),
    .cfg_ibuf_base   (cfg_ibuf_base),
    .cfg_wbuf_base   (cfg_wbuf_base),
    .cfg_bbuf_base   (cfg_bbuf_base),
    .cfg_obuf_base   (cfg_obuf_base),
    .busy            (busy),
    .done            (done),
    .acc_clear       (acc_clear),
    .ibuf_read_req   (ibuf_read_req),
    .ibuf_read_addr  (ibuf_read_addr),
    .wbuf_read_req   (wbuf_read_req),
    .wbuf_read_addr  (wbuf_read_addr),
    .bias_read_req   (bias_read_req),
    .bias_read_addr  (bias_read_addr),
    .bias_prev_sw    (bias_prev_sw),
    .obuf_read_req   (obuf_read_req),
    .obuf_read_addr  (obuf_read_addr),
    .obuf_write_req  (obuf_write_req),
    .obuf_write_addr (obuf_write_addr),
    .perf_cycle_count(perf_cycle_count)
  );

  // Cycle 0 is the cycle in which start=1 is sampled; cfg is scrambled afterwards to prove latching.
  task automatic run_tile(input logic [15:0] rows, input logic [15:0] k, input logic [15:0] ib,
                          input logic [15:0] wb, input logic [15:0] bb, input logic [15:0] ob,
                          input int restart_cyc, input int reset_cyc, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      rec_vec[c] = {busy, done, acc_clear, wbuf_read_req, ibuf_read_req, bias_read_req,
                    bias_prev_sw, obuf_read_req, obuf_write_req, wbuf_read_addr, ibuf_read_addr,
                    bias_read_addr, obuf_read_addr, obuf_write_addr};
      rec_perf[c] = perf_cycle_count;
      if (c == 0) begin
        cfg_num_rows = rows; cfg_num_k = k; cfg_ibuf_base = ib;
        cfg_wbuf_base = wb; cfg_bbuf_base = bb; cfg_obuf_base = ob;
        start = 1'b1;
      end else begin
        cfg_num_rows = ~rows; cfg_num_k = ~k; cfg_ibuf_base = ~ib;
        cfg_wbuf_base = ~wb; cfg_bbuf_base = ~bb; cfg_obuf_base = ~ob;
        start = (c == restart_cyc);
      end
      reset = (c == reset_cyc) ? 1'b0 : 1'b1;
    end
    start = 1'b0;
    reset = 1'b1;
  endtask

  function automatic logic [88:0] exp_two_pass(input int c);
    logic b, d, a, wq, iq, bq, sw, oq, wr;
    logic [15:0] wa, ia, ba, oa, wra;
    {b, d, a, wq, iq, bq, sw, oq, wr} = '0;
    {wa, ia, ba, oa, wra} = '0;
    b = (c >= 1 && c <= 45); d = (c == 45); a = (c == 1);
    sw = (c >= 19 && c <= 35);
    if (c == 2)  begin wq = 1'b1; wa = 16'h0200; end
    if (c == 19) begin wq = 1'b1; wa = 16'h0201; end
    if (c >= 3 && c <= 18) begin
      iq = 1'b1; ia = 16'h0100 + 16'(c - 3); bq = 1'b1; ba = 16'h0300;
    end
    if (c >= 20 && c <= 35) begin
      iq = 1'b1; ia = 16'h0110 + 16'(c - 20); oq = 1'b1; oa = 16'h0400 + 16'(c - 20);
    end
    if (c >= 12 && c <= 27) begin wr = 1'b1; wra = 16'h0400 + 16'(c - 12); end
    if (c >= 29 && c <= 44) begin wr = 1'b1; wra = 16'h0400 + 16'(c - 29); end
    return {b, d, a, wq, iq, bq, sw, oq, wr, wa, ia, ba, oa, wra};
  endfunction

  function automatic logic [88:0] exp_hazard(input int c);
    logic b, d, a, wq, iq, bq, sw, oq, wr;
    logic [15:0] wa, ia, ba, oa, wra;
    {b, d, a, wq, iq, bq, sw, oq, wr} = '0;
    {wa, ia, ba, oa, wra} = '0;
    b = (c >= 1 && c <= 30); d = (c == 30); a = (c == 1);
    sw = (c >= 16 && c <= 20);
    if (c == 2)  begin wq = 1'b1; wa = 16'h0020; end
    if (c == 16) begin wq = 1'b1; wa = 16'h0021; end
    if (c >= 3 && c <= 6) begin
      iq = 1'b1; ia = 16'h0010 + 16'(c - 3); bq = 1'b1; ba = 16'h0030;
    end
    if (c >= 17 && c <= 20) begin
      iq = 1'b1; ia = 16'h0014 + 16'(c - 17); oq = 1'b1; oa = 16'h0040 + 16'(c - 17);
    end
    if (c >= 12 && c <= 15) begin wr = 1'b1; wra = 16'h0040 + 16'(c - 12); end
    if (c >= 26 && c <= 29) begin wr = 1'b1; wra = 16'h0040 + 16'(c - 26); end
    return {b, d, a, wq, iq, bq, sw, oq, wr, wa, ia, ba, oa, wra};
  endfunction

  task automatic test_reset();
    reset = 1'b0; start = 1'b0;
    {cfg_num_rows, cfg_num_k, cfg_ibuf_base, cfg_wbuf_base, cfg_bbuf_base, cfg_obuf_base} = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, done, acc_clear, wbuf_read_req, ibuf_read_req, bias_read_req, bias_prev_sw,
         obuf_read_req, obuf_write_req, wbuf_read_addr, ibuf_read_addr, bias_read_addr,
         obuf_read_addr, obuf_write_addr, perf_cycle_count} !== 121'd0) begin
      n_err++;
      $display("FAIL reset_outputs got busy=%b done=%b perf=%h required all zero",
               busy, done, perf_cycle_count);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, obuf_write_req, ibuf_read_req} !== 4'b0) begin
      n_err++;
      $display("FAIL idle_after_reset got busy=%b done=%b wr=%b ird=%b required 0",
               busy, done, obuf_write_req, ibuf_read_req);
    end
  endtask

  task automatic test_two_pass();
    logic [88:0] e;
    run_tile(16'd16, 16'd2, 16'h0100, 16'h0200, 16'h0300, 16'h0400, -1, -1, 50);
    for (int c = 0; c < 50; c++) begin
      e = exp_two_pass(c);
      n_cmp++;
      if (rec_vec[c] !== e) begin
        n_err++;
        $display("FAIL two_pass cyc=%0d got=%h required=%h", c, rec_vec[c], e);
      end
    end
    n_cmp++;
    if (rec_perf[49] !== (PerfEn ? 32'd45 : 32'd0)) begin
      n_err++;
      $display("FAIL two_pass_perf got=%0d required=%0d", rec_perf[49], PerfEn ? 45 : 0);
    end
  endtask

  task automatic test_restart_ignored();
    logic [88:0] e;
    run_tile(16'd16, 16'd2, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 5, -1, 50);
    for (int c = 0; c < 50; c++) begin
      e = exp_two_pass(c);
      n_cmp++;
      if (rec_vec[c] !== e) begin
        n_err++;
        $display("FAIL restart_ignored cyc=%0d got=%h required=%h", c, rec_vec[c], e);
      end
    end
  endtask

  task automatic test_hazard();
    logic [88:0] e;
    logic        found;
    run_tile(16'd4, 16'd2, 16'h0010, 16'h0020, 16'h0030, 16'h0040, -1, -1, 36);
    for (int c = 0; c < 36; c++) begin
      e = exp_hazard(c);
      n_cmp++;
      if (rec_vec[c] !== e) begin
        n_err++;
        $display("FAIL hazard cyc=%0d got=%h required=%h", c, rec_vec[c], e);
      end
      if (rec_vec[c][81]) begin
        found = 1'b0;
        for (int j = 0; j < c; j++) begin
          if (rec_vec[j][80] && rec_vec[j][15:0] == rec_vec[c][31:16]) found = 1'b1;
        end
        n_cmp++;
        if (found !== 1'b1) begin
          n_err++;
          $display("FAIL hazard_raw cyc=%0d addr=%h got no prior write required one",
                   c, rec_vec[c][31:16]);
        end
      end
    end
    n_cmp++;
    if (rec_perf[35] !== (PerfEn ? 32'd30 : 32'd0)) begin
      n_err++;
      $display("FAIL hazard_perf got=%0d required=%0d", rec_perf[35], PerfEn ? 30 : 0);
    end
  endtask

  task automatic test_zero();
    logic [88:0] e;
    for (int t = 0; t < 2; t++) begin
      if (t == 0) run_tile(16'd0, 16'd3, 16'h0011, 16'h0022, 16'h0033, 16'h0044, -1, -1, 8);
      else        run_tile(16'd5, 16'd0, 16'h0011, 16'h0022, 16'h0033, 16'h0044, -1, -1, 8);
      for (int c = 0; c < 8; c++) begin
        e = '0;
        e[88] = (c == 1 || c == 2);
        e[87] = (c == 2);
        e[86] = (c == 1);
        n_cmp++;
        if (rec_vec[c] !== e) begin
          n_err++;
          $display("FAIL zero_tile t=%0d cyc=%0d got=%h required=%h", t, c, rec_vec[c], e);
        end
      end
      n_cmp++;
      if (rec_perf[7] !== (PerfEn ? 32'd2 : 32'd0)) begin
        n_err++;
        $display("FAIL zero_perf t=%0d got=%0d required=%0d", t, rec_perf[7], PerfEn ? 2 : 0);
      end
    end
  endtask

  task automatic test_abort();
    logic [88:0] e;
    run_tile(16'd16, 16'd2, 16'h0100, 16'h0200, 16'h0300, 16'h0400, -1, 10, 50);
    for (int c = 0; c < 50; c++) begin
      e = (c <= 10) ? exp_two_pass(c) : '0;
      n_cmp++;
      if (rec_vec[c] !== e || (c > 10 && rec_perf[c] !== 32'd0)) begin
        n_err++;
        $display("FAIL abort cyc=%0d got=%h perf=%0d required=%h perf=0",
                 c, rec_vec[c], rec_perf[c], e);
      end
    end
    run_tile(16'd16, 16'd2, 16'h0100, 16'h0200, 16'h0300, 16'h0400, -1, -1, 50);
    for (int c = 0; c < 50; c++) begin
      e = exp_two_pass(c);
      n_cmp++;
      if (rec_vec[c] !== e) begin
        n_err++;
        $display("FAIL abort_rerun cyc=%0d got=%h required=%h", c, rec_vec[c], e);
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] wexp [4];
    logic [17:0] got, req;
    wexp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    run_tile(16'd4, 16'd1, 16'h0000, 16'h0000, 16'h0010, 16'hFFFE, -1, -1, 20);
    for (int c = 0; c < 20; c++) begin
      got = {rec_vec[c][87], rec_vec[c][80], rec_vec[c][15:0]};
      req = '0;
      if (c >= 12 && c <= 15) req = {1'b0, 1'b1, wexp[c-12]};
      if (c == 16) req[17] = 1'b1;
      n_cmp++;
      if (got !== req) begin
        n_err++;
        $display("FAIL wrap cyc=%0d got done/wr/addr=%h required=%h", c, got, req);
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_pass();
    test_restart_ignored();
    test_hazard();
    test_zero();
    test_abort();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
